// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: width/depth derivation and
// elaboration-time parameter legality checks.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // AFULL_LVL must lie in 1..DEPTH and AEMPTY_LVL strictly below it.
  function automatic bit lvls_legal(input int unsigned depth, input int unsigned afull_lvl,
                                    input int unsigned aempty_lvl);
    return (afull_lvl >= 1) && (afull_lvl <= depth) && (aempty_lvl < afull_lvl);
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// DEPTH x DATA_SIZE storage: synchronous write, asynchronous read.
// Isolated so a vendor RAM macro can be dropped in.
module sfifo_ram #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  logic [DATA_SIZE-1:0] mem_q [1 << ADDR_SIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The output register is the head
// entry; the RAM holds the remaining count - rvalid words.
module sfifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned ADDR_SIZE  = 4,
  parameter int unsigned AFULL_LVL  = depth_of(ADDR_SIZE) - 2,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [DATA_SIZE-1:0] rdata_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [ADDR_SIZE:0]   count_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 ovf_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] FullCnt   = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AfullCnt  = (ADDR_SIZE + 1)'(AFULL_LVL);
  localparam logic [ADDR_SIZE:0] AemptyCnt = (ADDR_SIZE + 1)'(AEMPTY_LVL);

  if (!lvls_legal(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_lvl
    $error("sfifo_fwft: AFULL_LVL must be 1..DEPTH and AEMPTY_LVL below AFULL_LVL");
  end

  logic [ADDR_SIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d, ram_rdata;
  logic                 rvalid_q, rvalid_d, ovf_q, ovf_d;
  logic                 wready, push, pop, head_load, ram_empty, ram_we;

  assign wready    = (count_q != FullCnt) && !rst_i;
  assign push      = wvalid_i && wready;
  assign pop       = rvalid_q && rready_i;
  assign head_load = !rvalid_q || pop;
  // RAM is empty when everything held sits in the output register.
  assign ram_empty = (count_q == {{ADDR_SIZE{1'b0}}, rvalid_q});

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    ovf_d    = ovf_q;
    ram_we   = 1'b0;
    if (flush_i) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      rvalid_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (head_load) begin
        if (!ram_empty) begin
          rdata_d  = ram_rdata;
          rptr_d   = rptr_q + ADDR_SIZE'(1);
          rvalid_d = 1'b1;
        end else if (push) begin
          rdata_d  = wdata_i;
          rvalid_d = 1'b1;
        end else begin
          rvalid_d = 1'b0;
        end
      end
      if (push && !(head_load && ram_empty)) begin
        ram_we = 1'b1;
        wptr_d = wptr_q + ADDR_SIZE'(1);
      end
      if (push && !pop) count_d = count_q + (ADDR_SIZE + 1)'(1);
      else if (pop && !push) count_d = count_q - (ADDR_SIZE + 1)'(1);
      if (wvalid_i && !wready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  sfifo_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(wptr_q),
    .wdata_i(wdata_i),
    .raddr_i(rptr_q),
    .rdata_o(ram_rdata)
  );

  assign wready_o       = wready;
  assign rdata_o        = rdata_q;
  assign rvalid_o       = rvalid_q;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= AfullCnt);
  assign almost_empty_o = (count_q <= AemptyCnt);
  assign ovf_o          = ovf_q;

endmodule
